mcu_io_bridge: RTL and testbench



---
 rtl/mcu_io_pkg.sv | 23 ++
 rtl/mcu_io_bridge_strobe_sync.sv | 37 +++
 rtl/mcu_io_bridge.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_mcu_io_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_io_pkg.sv
// mcu_io_pkg: shared definitions for the MCU IO bridge.
//   - register offsets relative to FRAME_LEN (the first byte after the frame window)
//   - status register bit positions
//   - LCD capture FSM state encoding
package mcu_io_pkg;

  localparam int OFS_DIN  = 0;
  localparam int OFS_BUT  = 1;
  localparam int OFS_OUT  = 2;
  localparam int OFS_MASK = 3;
  localparam int OFS_STAT = 4;

  localparam int STAT_FRAME_VALID = 0;
  localparam int STAT_ARMED       = 1;
  localparam int STAT_OVERRUN     = 2;

  typedef enum logic [1:0] {
    LCD_IDLE    = 2'd0,
    LCD_ARMED   = 2'd1,
    LCD_CAPTURE = 2'd2
  } lcd_state_e;

endpackage

// File: rtl/mcu_io_bridge_strobe_sync.sv
// strobe_sync: brings an asynchronous strobe into clk and emits a one-cycle
// pulse for each rising edge.
//   clk      in  : system clock
//   rst      in  : synchronous, active-high reset
//   strobe_i in  : asynchronous strobe
//   pulse_o  out : registered one-cycle pulse, 3 cycles after the strobe rises
module strobe_sync
  import mcu_io_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= strobe_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/mcu_io_bridge.sv
// mcu_io_bridge: MCU parallel-bus bridge to LCD frame capture and board IO.
//   clk, rst                 : single clock, synchronous active-high reset
//   mem_sync/read/adr/wdata  : asynchronous MCU access strobe plus qualifiers
//   mem_rdata, mem_rdata_oe  : registered read data and pad-driver enable
//   lcd_sync/frame/en/data   : asynchronous LCD byte strobe plus qualifiers
//   lcd_rdy                  : a complete frame is available in the front buffer
//   in_din, in_but           : active-low asynchronous inputs and buttons
//   out_dout, led            : registered digital outputs and LEDs
// Frame bytes are captured into the back half of a ping-pong RAM; the halves
// swap only when a whole frame has landed, so the MCU never sees a torn frame.
module mcu_io_bridge
  import mcu_io_pkg::*;
#(
  parameter int          FRAME_LEN  = 2048,
  parameter int          ADR_W      = 12,
  parameter int          CMD_BYTE   = 132,
  parameter int          N_IN       = 6,
  parameter int          N_BUT      = 6,
  parameter int          N_OUT      = 6,
  parameter int          DEB_CYCLES = 16,
  parameter logic [7:0]  MASK_RST   = 8'hF7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_sync,
  input  logic             mem_read,
  input  logic [ADR_W-1:0] mem_adr,
  input  logic [7:0]       mem_wdata,
  output logic [7:0]       mem_rdata,
  output logic             mem_rdata_oe,
  input  logic             lcd_sync,
  input  logic             lcd_frame,
  input  logic             lcd_en,
  input  logic [7:0]       lcd_data,
  output logic             lcd_rdy,
  input  logic [N_IN-1:0]  in_din,
  input  logic [N_BUT-1:0] in_but,
  output logic [N_OUT-1:0] out_dout,
  output logic [N_OUT-1:0] led
);

  localparam int FB  = $clog2(FRAME_LEN);
  localparam int CW  = FB + 1;
  localparam int NDB = N_IN + N_BUT;
  localparam int DCW = $clog2(DEB_CYCLES + 1);

  // ---------------------------------------------------------------- strobes
  logic mem_pulse;
  logic lcd_pulse;

  strobe_sync u_mem_sync (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (mem_sync),
    .pulse_o  (mem_pulse)
  );

  strobe_sync u_lcd_sync (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (lcd_sync),
    .pulse_o  (lcd_pulse)
  );

  logic [1:0] rd_sync_q;

  always_ff @(posedge clk) begin
    if (rst) rd_sync_q <= 2'b00;
    else     rd_sync_q <= {rd_sync_q[0], mem_read};
  end

  assign mem_rdata_oe = rd_sync_q[1];

  // --------------------------------------------------------------- debounce
  // Inputs and buttons share one debounce bank: bits [N_IN-1:0] are din,
  // the rest are buttons. Synchronisers reset to the idle (high) level.
  logic [NDB-1:0] raw_in;
  logic [NDB-1:0] meta_in_q;
  logic [NDB-1:0] sync_in_q;
  logic [NDB-1:0] deb_val;

  assign raw_in = {in_but, in_din};

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_in_q <= '1;
      sync_in_q <= '1;
    end else begin
      meta_in_q <= raw_in;
      sync_in_q <= meta_in_q;
    end
  end

  for (genvar g = 0; g < NDB; g++) begin : g_deb
    logic           acc_q;
    logic           acc_d;
    logic [DCW-1:0] dcnt_q;
    logic [DCW-1:0] dcnt_d;
    logic           samp;

    assign samp = ~sync_in_q[g];

    always_comb begin
      acc_d  = acc_q;
      dcnt_d = dcnt_q;
      if (samp == acc_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DCW'(DEB_CYCLES - 1)) begin
        acc_d  = samp;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + DCW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q  <= 1'b0;
        dcnt_q <= '0;
      end else begin
        acc_q  <= acc_d;
        dcnt_q <= dcnt_d;
      end
    end

    assign deb_val[g] = acc_q;
  end

  logic [7:0] din_byte;
  logic [7:0] but_byte;

  assign din_byte = 8'(deb_val[N_IN-1:0]);
  assign but_byte = 8'(deb_val[NDB-1:N_IN]);

  // ---------------------------------------------------------- control state
  lcd_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             front_q, front_d;
  logic             frame_valid_q, frame_valid_d;
  logic             lcd_rdy_q, lcd_rdy_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       out_val_q, out_val_d;
  logic [7:0]       ovr_mask_q, ovr_mask_d;
  logic [7:0]       reg_rd_q, reg_rd_d;
  logic             rd_frame_q, rd_frame_d;
  logic [N_OUT-1:0] out_dout_q, out_dout_d;
  logic [N_OUT-1:0] led_q;
  logic             ovr_set;
  logic             ram_we;
  logic [FB:0]      ram_waddr;
  logic [FB:0]      ram_raddr;

  // ------------------------------------------------------------ LCD capture
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    front_d       = front_q;
    frame_valid_d = frame_valid_q;
    lcd_rdy_d     = lcd_rdy_q;
    ovr_set       = 1'b0;
    ram_we        = 1'b0;
    ram_waddr     = {~front_q, cnt_q[FB-1:0]};

    // The swap is evaluated the cycle after the last byte's edge. The minimum
    // strobe width guarantees no further LCD pulse can land in that cycle.
    if (state_q == LCD_CAPTURE && cnt_q == CW'(FRAME_LEN)) begin
      front_d       = ~front_q;
      frame_valid_d = 1'b1;
      lcd_rdy_d     = 1'b1;
      state_d       = LCD_IDLE;
    end else if (lcd_pulse) begin
      if (!lcd_frame) begin
        cnt_d = '0;
        if (lcd_en && lcd_data == 8'(CMD_BYTE)) begin
          state_d   = LCD_ARMED;
          lcd_rdy_d = 1'b0;
          // Re-arming before the frame completed: the partial back buffer
          // is simply overwritten by the next capture.
          ovr_set   = (state_q != LCD_IDLE);
        end
      end else if (cnt_q < CW'(FRAME_LEN)) begin
        if (state_q != LCD_IDLE) begin
          ram_we  = 1'b1;
          state_d = LCD_CAPTURE;
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // ------------------------------------------------------- MCU register map
  logic       in_frame;
  logic       sel_din, sel_but, sel_out, sel_mask, sel_stat;
  logic [7:0] status_byte;
  logic [7:0] reg_rd_val;

  assign in_frame = (mem_adr < ADR_W'(FRAME_LEN));
  assign sel_din  = (mem_adr == ADR_W'(FRAME_LEN + OFS_DIN));
  assign sel_but  = (mem_adr == ADR_W'(FRAME_LEN + OFS_BUT));
  assign sel_out  = (mem_adr == ADR_W'(FRAME_LEN + OFS_OUT));
  assign sel_mask = (mem_adr == ADR_W'(FRAME_LEN + OFS_MASK));
  assign sel_stat = (mem_adr == ADR_W'(FRAME_LEN + OFS_STAT));

  always_comb begin
    status_byte                   = 8'h00;
    status_byte[STAT_FRAME_VALID] = frame_valid_q;
    status_byte[STAT_ARMED]       = (state_q != LCD_IDLE);
    status_byte[STAT_OVERRUN]     = overrun_q;
  end

  always_comb begin
    reg_rd_val = 8'h00;
    if (sel_din)  reg_rd_val = din_byte;
    if (sel_but)  reg_rd_val = but_byte;
    if (sel_out)  reg_rd_val = out_val_q;
    if (sel_mask) reg_rd_val = ovr_mask_q;
    if (sel_stat) reg_rd_val = status_byte;
  end

  always_comb begin
    out_val_d  = out_val_q;
    ovr_mask_d = ovr_mask_q;
    overrun_d  = overrun_q;
    reg_rd_d   = reg_rd_q;
    rd_frame_d = rd_frame_q;
    if (mem_pulse) begin
      if (mem_read) begin
        reg_rd_d   = reg_rd_val;
        rd_frame_d = in_frame && frame_valid_q;
        if (sel_stat) overrun_d = 1'b0;
      end else begin
        if (sel_out)  out_val_d  = mem_wdata;
        if (sel_mask) ovr_mask_d = mem_wdata;
      end
    end
    // A new overrun in the same cycle as a status read must not be lost.
    if (ovr_set) overrun_d = 1'b1;
  end

  always_comb begin
    out_dout_d = (ovr_mask_q[N_OUT-1:0] & out_val_q[N_OUT-1:0]) |
                 (~ovr_mask_q[N_OUT-1:0] & deb_val[N_OUT-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LCD_IDLE;
      cnt_q         <= '0;
      front_q       <= 1'b0;
      frame_valid_q <= 1'b0;
      lcd_rdy_q     <= 1'b0;
      overrun_q     <= 1'b0;
      out_val_q     <= 8'h00;
      ovr_mask_q    <= MASK_RST;
      reg_rd_q      <= 8'h00;
      rd_frame_q    <= 1'b0;
      out_dout_q    <= '0;
      led_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      front_q       <= front_d;
      frame_valid_q <= frame_valid_d;
      lcd_rdy_q     <= lcd_rdy_d;
      overrun_q     <= overrun_d;
      out_val_q     <= out_val_d;
      ovr_mask_q    <= ovr_mask_d;
      reg_rd_q      <= reg_rd_d;
      rd_frame_q    <= rd_frame_d;
      out_dout_q    <= out_dout_d;
      led_q         <= out_val_q[N_OUT-1:0];
    end
  end

  // ------------------------------------------------------- ping-pong buffer
  // Upper address bit selects the half: the MCU reads the front half, the
  // LCD writes the other one.
  logic [7:0] ram [2*FRAME_LEN];
  logic [7:0] ram_rd_q;

  assign ram_raddr = {front_q, mem_adr[FB-1:0]};

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= lcd_data;
    if (mem_pulse && mem_read) ram_rd_q <= ram[ram_raddr];
  end

  assign mem_rdata = rd_frame_q ? ram_rd_q : reg_rd_q;
  assign lcd_rdy   = lcd_rdy_q;
  assign out_dout  = out_dout_q;
  assign led       = led_q;

endmodule

// File: tb/tb_mcu_io_bridge.sv
module tb_mcu_io_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_sync;
  logic        mem_read;
  logic [11:0] mem_adr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_rdata_oe;
  logic        lcd_sync;
  logic        lcd_frame;
  logic        lcd_en;
  logic [7:0]  lcd_data;
  logic        lcd_rdy;
  logic [5:0]  in_din;
  logic [5:0]  in_but;
  logic [5:0]  out_dout;
  logic [5:0]  led;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [11:0] B = 12'd2048;

  always #5 clk = ~clk;

  mcu_io_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .mem_sync     (mem_sync),
    .mem_read     (mem_read),
    .mem_adr      (mem_adr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rdata_oe (mem_rdata_oe),
    .lcd_sync     (lcd_sync),
    .lcd_frame    (lcd_frame),
    .lcd_en       (lcd_en),
    .lcd_data     (lcd_data),
    .lcd_rdy      (lcd_rdy),
    .in_din       (in_din),
    .in_but       (in_but),
    .out_dout     (out_dout),
    .led          (led)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_sync  = 1'b0;
    mem_read  = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    lcd_sync  = 1'b0;
    lcd_frame = 1'b0;
    lcd_en    = 1'b0;
    lcd_data  = '0;
    in_din    = '1;
    in_but    = '1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic mcu_wr(input logic [11:0] a, input logic [7:0] d);
    mem_read  = 1'b0;
    mem_adr   = a;
    mem_wdata = d;
    mem_sync  = 1'b1;
    tick(3);
    mem_sync  = 1'b0;
    tick(3);
  endtask

  task automatic mcu_rd(input logic [11:0] a, output logic [7:0] d);
    mem_read = 1'b1;
    mem_adr  = a;
    mem_sync = 1'b1;
    tick(3);
    mem_sync = 1'b0;
    tick(3);
    d = mem_rdata;
  endtask

  task automatic lcd_byte(input logic fr, input logic en, input logic [7:0] d);
    lcd_frame = fr;
    lcd_en    = en;
    lcd_data  = d;
    lcd_sync  = 1'b1;
    tick(3);
    lcd_sync  = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    logic [7:0] r;
    do_reset();
    n_cmp++; if (mem_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got %h want 00", mem_rdata); end
    n_cmp++; if (mem_rdata_oe !== 1'b0) begin n_bad++; $display("FAIL rst_oe: got %b want 0", mem_rdata_oe); end
    n_cmp++; if (lcd_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_lcd_rdy: got %b want 0", lcd_rdy); end
    n_cmp++; if (out_dout !== 6'h00) begin n_bad++; $display("FAIL rst_dout: got %h want 00", out_dout); end
    n_cmp++; if (led !== 6'h00) begin n_bad++; $display("FAIL rst_led: got %h want 00", led); end
    mcu_rd(B + 12'd3, r);
    n_cmp++; if (r !== 8'hF7) begin n_bad++; $display("FAIL rst_mask: got %h want f7", r); end
    n_cmp++; if (mem_rdata_oe !== 1'b1) begin n_bad++; $display("FAIL rd_oe: got %b want 1", mem_rdata_oe); end
    mcu_rd(B + 12'd4, r);
    n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL rst_status: got %h want 00", r); end
    mcu_rd(12'd5, r);
    n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL rst_frame_rd: got %h want 00", r); end
    mcu_wr(B + 12'd6, 8'h00);
    n_cmp++; if (mem_rdata_oe !== 1'b0) begin n_bad++; $display("FAIL wr_oe: got %b want 0", mem_rdata_oe); end
  endtask

  task automatic test_frame_capture();
    logic [7:0] r;
    lcd_byte(1'b0, 1'b1, 8'd132);
    mcu_rd(B + 12'd4, r);
    n_cmp++; if (r !== 8'h02) begin n_bad++; $display("FAIL cap_armed_status: got %h want 02", r); end
    for (int i = 0; i < 2048; i++) lcd_byte(1'b1, 1'b0, 8'((i * 3) & 255));
    n_cmp++; if (lcd_rdy !== 1'b1) begin n_bad++; $display("FAIL cap_lcd_rdy: got %b want 1", lcd_rdy); end
    mcu_rd(B + 12'd4, r);
    n_cmp++; if (r !== 8'h01) begin n_bad++; $display("FAIL cap_status: got %h want 01", r); end
    mcu_rd(12'd10, r);
    n_cmp++; if (r !== 8'h1E) begin n_bad++; $display("FAIL cap_addr10: got %h want 1e", r); end
    mcu_rd(12'd2047, r);
    n_cmp++; if (r !== 8'hFD) begin n_bad++; $display("FAIL cap_addr2047: got %h want fd", r); end
  endtask

  task automatic test_ping_pong();
    logic [7:0] r;
    lcd_byte(1'b0, 1'b1, 8'd132);
    for (int i = 0; i < 2048; i++) lcd_byte(1'b1, 1'b0, 8'h11);
    n_cmp++; if (lcd_rdy !== 1'b1) begin n_bad++; $display("FAIL pp_rdy_a: got %b want 1", lcd_rdy); end
    lcd_byte(1'b0, 1'b1, 8'd132);
    n_cmp++; if (lcd_rdy !== 1'b0) begin n_bad++; $display("FAIL pp_rdy_armed: got %b want 0", lcd_rdy); end
    for (int i = 0; i < 100; i++) lcd_byte(1'b1, 1'b0, 8'h22);
    mcu_rd(12'd0, r);
    n_cmp++; if (r !== 8'h11) begin n_bad++; $display("FAIL pp_mid_b: got %h want 11", r); end
    for (int i = 100; i < 2048; i++) lcd_byte(1'b1, 1'b0, 8'h22);
    mcu_rd(12'd0, r);
    n_cmp++; if (r !== 8'h22) begin n_bad++; $display("FAIL pp_after_b: got %h want 22", r); end
    mcu_rd(B + 12'd4, r);
    n_cmp++; if (r !== 8'h01) begin n_bad++; $display("FAIL pp_status: got %h want 01", r); end
  endtask

  task automatic test_write_protect();
    logic [7:0] r;
    mcu_wr(12'd0, 8'h99);
    mcu_rd(12'd0, r);
    n_cmp++; if (r !== 8'h22) begin n_bad++; $display("FAIL wp_frame: got %h want 22", r); end
    mcu_wr(B + 12'd4, 8'hFF);
    mcu_rd(B + 12'd4, r);
    n_cmp++; if (r !== 8'h01) begin n_bad++; $display("FAIL wp_status: got %h want 01", r); end
    mcu_wr(B + 12'd6, 8'hAA);
    mcu_rd(B + 12'd6, r);
    n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL wp_unmapped: got %h want 00", r); end
  endtask

  task automatic test_overrun();
    logic [7:0] r;
    do_reset();
    lcd_byte(1'b0, 1'b1, 8'd132);
    for (int i = 0; i < 100; i++) lcd_byte(1'b1, 1'b0, 8'h33);
    lcd_byte(1'b0, 1'b1, 8'd132);
    mcu_rd(B + 12'd4, r);
    n_cmp++; if (r !== 8'h06) begin n_bad++; $display("FAIL ovr_status1: got %h want 06", r); end
    mcu_rd(B + 12'd4, r);
    n_cmp++; if (r !== 8'h02) begin n_bad++; $display("FAIL ovr_status2: got %h want 02", r); end
    n_cmp++; if (lcd_rdy !== 1'b0) begin n_bad++; $display("FAIL ovr_rdy: got %b want 0", lcd_rdy); end
  endtask

  task automatic test_reset_mid_capture();
    logic [7:0] r;
    lcd_byte(1'b0, 1'b1, 8'd132);
    for (int i = 0; i < 50; i++) lcd_byte(1'b1, 1'b0, 8'h44);
    do_reset();
    n_cmp++; if (lcd_rdy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rdy: got %b want 0", lcd_rdy); end
    for (int i = 0; i < 10; i++) lcd_byte(1'b1, 1'b0, 8'h55);
    lcd_byte(1'b0, 1'b0, 8'd132);
    lcd_byte(1'b0, 1'b1, 8'd133);
    mcu_rd(B + 12'd4, r);
    n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL mid_rst_status: got %h want 00", r); end
  endtask

  task automatic test_debounce_override();
    logic [7:0] r;
    in_din[3] = 1'b0;
    tick(15);
    in_din[3] = 1'b1;
    tick(30);
    n_cmp++; if (out_dout !== 6'h00) begin n_bad++; $display("FAIL deb_glitch: got %h want 00", out_dout); end
    in_din[3] = 1'b0;
    tick(18);
    n_cmp++; if (out_dout !== 6'h00) begin n_bad++; $display("FAIL deb_early: got %h want 00", out_dout); end
    tick(1);
    n_cmp++; if (out_dout !== 6'h08) begin n_bad++; $display("FAIL deb_accept: got %h want 08", out_dout); end
    mcu_rd(B + 12'd0, r);
    n_cmp++; if (r !== 8'h08) begin n_bad++; $display("FAIL deb_din_rd: got %h want 08", r); end
    mcu_wr(B + 12'd3, 8'h3F);
    mcu_wr(B + 12'd2, 8'h05);
    n_cmp++; if (out_dout !== 6'h05) begin n_bad++; $display("FAIL ovr_dout: got %h want 05", out_dout); end
    n_cmp++; if (led !== 6'h05) begin n_bad++; $display("FAIL ovr_led: got %h want 05", led); end
    mcu_rd(B + 12'd2, r);
    n_cmp++; if (r !== 8'h05) begin n_bad++; $display("FAIL outval_rd: got %h want 05", r); end
    mcu_wr(B + 12'd3, 8'h00);
    n_cmp++; if (out_dout !== 6'h08) begin n_bad++; $display("FAIL mask0_dout: got %h want 08", out_dout); end
    n_cmp++; if (led !== 6'h05) begin n_bad++; $display("FAIL mask0_led: got %h want 05", led); end
  endtask

  task automatic test_buttons();
    logic [7:0] r;
    in_but = 6'b011110;
    tick(25);
    mcu_rd(B + 12'd1, r);
    n_cmp++; if (r !== 8'h21) begin n_bad++; $display("FAIL but_rd: got %h want 21", r); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_capture();
    test_ping_pong();
    test_write_protect();
    test_overrun();
    test_reset_mid_capture();
    test_debounce_override();
    test_buttons();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
